// File: rtl/riscv_defs.sv
// riscv_defs: shared RV32 load/store definitions for the data memory slice.
//   funct3_e : funct3 encodings for byte/half/word accesses (signed and unsigned loads)
//   CNT_W    : width of the saturating access counters
package riscv_defs;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load formatter and access checker.
//   word_i       : raw 32-bit memory word at the addressed index
//   byte_off_i   : addr[1:0]
//   funct3_i     : access type
//   is_store_i   : access is a store (stores accept only B/H/W)
//   data_o       : selected byte/half shifted to bit 0 and sign/zero extended
//   misaligned_o : halfword on odd address or word not on a 4-byte boundary
//   illegal_o    : funct3 not valid for this access direction
module dmem_load_align
    import riscv_defs::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    output logic [31:0] data_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel     = 8'(word_i >> {byte_off_i, 3'b000});
        half_sel     = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        data_o       = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: begin
                data_o    = {24'h0, byte_sel};
                illegal_o = is_store_i;
            end
            F3_H: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = byte_off_i[0];
            end
            F3_HU: begin
                data_o       = {16'h0, half_sel};
                misaligned_o = byte_off_i[0];
                illegal_o    = is_store_i;
            end
            F3_W: begin
                data_o       = word_i;
                misaligned_o = |byte_off_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// data_mem: word-organised RV32 data memory with load/store formatting.
//   clk, rst           : clock, asynchronous active-high reset (clears memory too)
//   mem_read/mem_write : access strobes; both high is handled as a store
//   funct3             : access type
//   addr               : byte address; bits above DEPTH_LOG2+1 are ignored
//   wdata              : store data
//   rdata              : combinational formatted load data (0 when idle or faulting)
//   fault              : combinational misaligned/illegal flag for the current access
//   fault_sticky       : latched fault indication, cleared by rst
//   load_count         : saturating count of completed loads
//   store_count        : saturating count of completed stores
// Build option: define DMEM_STATS_EN to build the access counters; otherwise
// load_count/store_count are tied to 0.
module data_mem
    import riscv_defs::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned size       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [size-1:0]  wdata,
    output logic [size-1:0]  rdata,
    output logic             fault,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           ld_data;
    logic                  misaligned;
    logic                  illegal;
    logic                  do_store;
    logic [3:0]            lane_en;
    logic [31:0]           wr_word;
    logic                  fault_sticky_q;
    logic                  unused_addr_hi;

    assign idx            = addr[DEPTH_LOG2+1:2];
    assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

    dmem_load_align u_align (
        .word_i       (mem_q[idx]),
        .byte_off_i   (addr[1:0]),
        .funct3_i     (funct3),
        .is_store_i   (mem_write),
        .data_o       (ld_data),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    assign fault    = (mem_read | mem_write) & (misaligned | illegal);
    assign do_store = mem_write & ~fault;
    // With both strobes high the array still holds the pre-write word here,
    // which gives read-before-write behaviour for free.
    assign rdata    = (mem_read && !fault) ? ld_data : '0;

    // Store data is replicated across lanes so each lane enable just picks
    // its own byte out of wr_word.
    always_comb begin
        lane_en = '0;
        wr_word = wdata;
        case (funct3)
            F3_B: begin
                lane_en = 4'b0001 << addr[1:0];
                wr_word = {4{wdata[7:0]}};
            end
            F3_H: begin
                lane_en = addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata[15:0]}};
            end
            F3_W:    lane_en = 4'b1111;
            default: lane_en = '0;
        endcase
        if (!do_store) lane_en = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (lane_en[j]) mem_q[idx][8*j +: 8] <= wr_word[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        fault_sticky_q <= 1'b0;
        else if (fault) fault_sticky_q <= 1'b1;
    end
    assign fault_sticky = fault_sticky_q;

`ifdef DMEM_STATS_EN
    logic             do_load;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

    assign do_load = mem_read & ~mem_write & ~fault;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (do_load && load_cnt_q != '1)   load_cnt_d  = load_cnt_q + CNT_W'(1);
        if (do_store && store_cnt_q != '1) store_cnt_d = store_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
`else
    assign load_count  = '0;
    assign store_count = '0;
`endif

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    localparam int unsigned DL2    = 8;
    localparam int unsigned NBYTES = 4 << DL2;
`ifdef DMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        fault;
    logic        fault_sticky;
    logic [15:0] load_count;
    logic [15:0] store_count;

    always #5 clk = ~clk;

    data_mem #(.DEPTH_LOG2(DL2), .size(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .fault        (fault),
        .fault_sticky (fault_sticky),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        logic        sticky;
        logic [15:0] lc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: byte-addressed array plus plain counters.
    byte unsigned m_mem [NBYTES];
    bit           m_sticky;
    int           m_lc;
    int           m_sc;

    function automatic void model_clear();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_sticky = 1'b0;
        m_lc     = 0;
        m_sc     = 0;
    endfunction

    function automatic int unsigned acc_bytes(logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit mdl_fault(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        bit illegal;
        if (!(rd || wr)) return 1'b0;
        if (wr) illegal = (f3 > 3'd2);
        else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (illegal) return 1'b1;
        return (a % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(logic [2:0] f3, logic [31:0] a);
        int unsigned n    = acc_bytes(f3);
        int unsigned base = a % NBYTES;
        longint      v    = 0;
        for (int k = 0; k < int'(n); k++) v += longint'(m_mem[base + k]) << (8 * k);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Called just after a rising edge: drive, predict, wait for the capturing edge, update model.
    task automatic cycle(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        bit          f;
        int unsigned n;
        int unsigned base;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        f         = mdl_fault(rd, wr, f3, a);
        e.name    = nm;
        e.fault   = f;
        e.rdata   = (rd && !f) ? mdl_load(f3, a) : 32'h0;
        e.sticky  = m_sticky;
        e.lc      = STATS ? 16'(m_lc) : 16'h0;
        e.sc      = STATS ? 16'(m_sc) : 16'h0;
        sb.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (f) begin
                m_sticky = 1'b1;
            end else if (wr) begin
                n    = acc_bytes(f3);
                base = a % NBYTES;
                for (int k = 0; k < int'(n); k++) m_mem[base + k] = 8'(wd >> (8 * k));
                if (m_sc < 65535) m_sc++;
            end else if (rd) begin
                if (m_lc < 65535) m_lc++;
            end
        end
        #1;
    endtask

    function automatic void chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, what, act, exp);
        end
    endfunction

    // Monitor: outputs are settled at the falling edge of each driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "rdata", rdata, e.rdata);
                chk(e.name, "fault", 32'(fault), 32'(e.fault));
                chk(e.name, "sticky", 32'(fault_sticky), 32'(e.sticky));
                chk(e.name, "load_count", 32'(load_count), 32'(e.lc));
                chk(e.name, "store_count", 32'(store_count), 32'(e.sc));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi;
        logic [31:0] a;
        int unsigned op;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        cycle("rst_lw", 1, 0, 3'b010, 32'h0, 32'h0);
        rst = 1'b0;
        cycle("lw0", 1, 0, 3'b010, 32'h0, 32'h0);

        cycle("sw10", 0, 1, 3'b010, 32'h10, 32'h80FF7F01);
        cycle("lb10", 1, 0, 3'b000, 32'h10, 32'h0);
        cycle("lb13", 1, 0, 3'b000, 32'h13, 32'h0);
        cycle("lbu13", 1, 0, 3'b100, 32'h13, 32'h0);
        cycle("lh12", 1, 0, 3'b001, 32'h12, 32'h0);
        cycle("lhu12", 1, 0, 3'b101, 32'h12, 32'h0);
        cycle("lw10_wrap", 1, 0, 3'b010, 32'h10 + NBYTES, 32'h0);

        cycle("sw20", 0, 1, 3'b010, 32'h20, 32'h11223344);
        cycle("sb21", 0, 1, 3'b000, 32'h21, 32'h123456AA);
        cycle("lw20a", 1, 0, 3'b010, 32'h20, 32'h0);
        cycle("sh22", 0, 1, 3'b001, 32'h22, 32'h5555BEEF);
        cycle("lw20b", 1, 0, 3'b010, 32'h20, 32'h0);

        cycle("sw30", 0, 1, 3'b010, 32'h30, 32'hCAFEF00D);
        cycle("sw31_mis", 0, 1, 3'b010, 32'h31, 32'hDEADBEEF);
        cycle("lw30", 1, 0, 3'b010, 32'h30, 32'h0);
        cycle("lh33_mis", 1, 0, 3'b001, 32'h33, 32'h0);
        cycle("ld_f3_3", 1, 0, 3'b011, 32'h30, 32'h0);
        cycle("ld_f3_6", 1, 0, 3'b110, 32'h30, 32'h0);
        cycle("st_f3_4", 0, 1, 3'b100, 32'h30, 32'h0);
        cycle("lw30_again", 1, 0, 3'b010, 32'h30, 32'h0);

        cycle("sw40", 0, 1, 3'b010, 32'h40, 32'h7);
        cycle("rw40", 1, 1, 3'b010, 32'h40, 32'h5);
        cycle("lw40", 1, 0, 3'b010, 32'h40, 32'h0);
        cycle("rw_bu_illegal", 1, 1, 3'b100, 32'h40, 32'h9);
        cycle("idle", 0, 0, 3'b111, 32'h41, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            hi = $urandom;
            a  = (hi & 32'hFFFFFC00) | 32'($urandom_range(0, 127));
            op = $urandom_range(0, 3);
            cycle("rand", op[0], op[1], 3'($urandom_range(0, 7)), a, $urandom);
        end

        for (int i = 0; i < 70000; i++) begin
            cycle("sat_lw", 1, 0, 3'b010, 32'($urandom_range(0, 255)) << 2, 32'h0);
        end
        cycle("sat_hold", 0, 0, 3'b010, 32'h0, 32'h0);

        // Asynchronous reset mid-cycle: cleared state must show before any edge.
        rst = 1'b1;
        model_clear();
        cycle("rst_lw10", 1, 0, 3'b010, 32'h10, 32'h0);
        cycle("rst_sw50", 0, 1, 3'b010, 32'h50, 32'h99);
        rst = 1'b0;
        cycle("rel_sw54", 0, 1, 3'b010, 32'h54, 32'h1234);
        cycle("lw50", 1, 0, 3'b010, 32'h50, 32'h0);
        cycle("lw54", 1, 0, 3'b010, 32'h54, 32'h0);
        cycle("lw20_cleared", 1, 0, 3'b010, 32'h20, 32'h0);

        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
